// File: rtl/tl_a_burst_arbiter_if.sv
// Shared A-channel handshake bundle between the hosts/device side and the burst arbiter.
// The arbiter takes the slave view; the environment driving requests takes the master view.
interface tl_a_burst_arbiter_if #(
    parameter int unsigned NumHosts  = 2,
    parameter int unsigned SizeWidth = 3,
    parameter int unsigned SelWidth  = (NumHosts > 1) ? $clog2(NumHosts) : 1
);
    logic [NumHosts-1:0]           req_valid_i;
    logic [NumHosts-1:0]           req_ready_o;
    logic [NumHosts*3-1:0]         req_opcode_i;
    logic [NumHosts*SizeWidth-1:0] req_size_i;
    logic                          dev_valid_o;
    logic                          dev_ready_i;
    logic [SelWidth-1:0]           sel_o;
    logic                          busy_o;

    modport slave (
        input  req_valid_i, req_opcode_i, req_size_i, dev_ready_i,
        output req_ready_o, dev_valid_o, sel_o, busy_o
    );

    modport master (
        output req_valid_i, req_opcode_i, req_size_i, dev_ready_i,
        input  req_ready_o, dev_valid_o, sel_o, busy_o
    );
endinterface

// File: rtl/tl_a_burst_arbiter.sv
// Round-robin arbiter sharing one TileLink A-channel device port between NumHosts hosts.
// Holds the grant through stalls and locks it across every beat of a multi-beat data burst.
module tl_a_burst_arbiter #(
    parameter int unsigned NumHosts  = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned SizeWidth = 3,
    parameter int unsigned MaxSize   = 6,
    parameter int unsigned SelWidth  = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    tl_a_burst_arbiter_if.slave    a_bus
);

    localparam int unsigned OffW = $clog2(DataWidth / 8);
    localparam int unsigned CntW = (MaxSize > OffW) ? (MaxSize - OffW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_BURST
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SelWidth-1:0] r_locked;
    logic [SelWidth-1:0] w_locked_nxt;
    logic [SelWidth-1:0] r_rr;
    logic [SelWidth-1:0] w_rr_nxt;
    logic [CntW-1:0]     r_rem;
    logic [CntW-1:0]     w_rem_nxt;

    logic [2:0]           w_op_arr   [NumHosts];
    logic [SizeWidth-1:0] w_size_arr [NumHosts];

    logic [SelWidth-1:0]  w_cand;
    logic                 w_any;
    logic [SelWidth-1:0]  w_sel;
    logic [2:0]           w_sel_op;
    logic [SizeWidth-1:0] w_sel_size;
    logic                 w_sel_valid;
    logic                 w_multi;
    logic [CntW-1:0]      w_beats_m1;
    logic                 w_fire;
    logic                 w_dev_valid;
    logic [NumHosts-1:0]  w_ready;

    for (genvar g = 0; g < NumHosts; g++) begin : g_unpack
        assign w_op_arr[g]   = a_bus.req_opcode_i[3*g +: 3];
        assign w_size_arr[g] = a_bus.req_size_i[SizeWidth*g +: SizeWidth];
    end

    assign w_any = |a_bus.req_valid_i;

    // First valid host strictly after the last granted one, wrapping around.
    always_comb begin
        logic                found;
        logic [SelWidth-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int unsigned k = 1; k <= NumHosts; k++) begin
            idx = SelWidth'((32'(r_rr) + k) % NumHosts);
            if (!found && a_bus.req_valid_i[idx]) begin
                found  = 1'b1;
                w_cand = idx;
            end
        end
    end

    assign w_sel       = (r_state == S_IDLE) ? w_cand : r_locked;
    assign w_sel_op    = w_op_arr[w_sel];
    assign w_sel_size  = w_size_arr[w_sel];
    assign w_sel_valid = a_bus.req_valid_i[w_sel];
    assign w_fire      = w_dev_valid && a_bus.dev_ready_i;

    // Remaining beats after the first; oversize requests saturate the counter.
    always_comb begin
        w_multi    = (w_sel_op < 3'd4) && (32'(w_sel_size) > OffW);
        w_beats_m1 = '0;
        if (w_multi) begin
            if (32'(w_sel_size) > MaxSize) begin
                w_beats_m1 = '1;
            end else begin
                w_beats_m1 = CntW'((32'd1 << (32'(w_sel_size) - OffW)) - 32'd1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_locked_nxt = r_locked;
        w_rr_nxt     = r_rr;
        w_rem_nxt    = r_rem;
        w_dev_valid  = 1'b0;
        w_ready      = '0;
        unique case (r_state)
            S_IDLE: begin
                w_dev_valid = w_any;
                if (w_any) begin
                    w_ready[w_cand] = a_bus.dev_ready_i;
                    if (a_bus.dev_ready_i) begin
                        w_rr_nxt = w_cand;
                        if (w_multi) begin
                            w_rem_nxt    = w_beats_m1;
                            w_locked_nxt = w_cand;
                            w_state_nxt  = S_BURST;
                        end
                    end else begin
                        w_locked_nxt = w_cand;
                        w_state_nxt  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                w_dev_valid       = w_sel_valid;
                w_ready[r_locked] = a_bus.dev_ready_i;
                if (w_sel_valid && a_bus.dev_ready_i) begin
                    w_rr_nxt = r_locked;
                    if (w_multi) begin
                        w_rem_nxt   = w_beats_m1;
                        w_state_nxt = S_BURST;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (!w_sel_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BURST: begin
                w_dev_valid       = w_sel_valid;
                w_ready[r_locked] = a_bus.dev_ready_i;
                if (w_fire) begin
                    w_rem_nxt = r_rem - CntW'(1);
                    if (r_rem == CntW'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_locked <= '0;
            r_rr     <= SelWidth'(NumHosts - 1);
            r_rem    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_locked <= w_locked_nxt;
            r_rr     <= w_rr_nxt;
            r_rem    <= w_rem_nxt;
        end
    end

    assign a_bus.req_ready_o = w_ready;
    assign a_bus.dev_valid_o = w_dev_valid;
    assign a_bus.sel_o       = w_sel;
    assign a_bus.busy_o      = (r_state != S_IDLE);

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(w_ready));

    a_single_fire: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(a_bus.req_valid_i & w_ready));

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == S_HOLD && w_state_nxt == S_HOLD) |=> ($stable(w_sel) && $stable(w_dev_valid)));

    a_legal_size: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_dev_valid && r_state != S_BURST && w_sel_op < 3'd4 && 32'(w_sel_size) > MaxSize));

endmodule

// File: tb/tb_tl_a_burst_arbiter.sv
// Directed bench for tl_a_burst_arbiter: per-cycle vector table plus a mid-burst reset sequence.
module tb_tl_a_burst_arbiter;

    localparam logic [2:0] GET = 3'd4;
    localparam logic [2:0] PF  = 3'd0;

    logic clk_i;
    logic rst_ni;

    tl_a_burst_arbiter_if #(.NumHosts(2), .SizeWidth(3)) u_if ();

    tl_a_burst_arbiter #(
        .NumHosts (2),
        .DataWidth(64),
        .SizeWidth(3),
        .MaxSize  (6)
    ) u_dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .a_bus (u_if.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] vld;
        logic [2:0] op0;
        logic [2:0] sz0;
        logic [2:0] op1;
        logic [2:0] sz1;
        logic       rdy;
        logic       rstn;
        logic       e_dv;
        logic [1:0] e_rdy;
        logic       e_sel;
        logic       e_busy;
    } vec_t;

    int n_tests;
    int n_fail;
    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] vld, logic [2:0] op0, logic [2:0] sz0,
                                logic [2:0] op1, logic [2:0] sz1, logic rdy, logic rstn,
                                logic e_dv, logic [1:0] e_rdy, logic e_sel, logic e_busy);
        vec_t v;
        v.vld = vld; v.op0 = op0; v.sz0 = sz0; v.op1 = op1; v.sz1 = sz1;
        v.rdy = rdy; v.rstn = rstn;
        v.e_dv = e_dv; v.e_rdy = e_rdy; v.e_sel = e_sel; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        u_if.req_valid_i  = v.vld;
        u_if.req_opcode_i = {v.op1, v.op0};
        u_if.req_size_i   = {v.sz1, v.sz0};
        u_if.dev_ready_i  = v.rdy;
        rst_ni            = v.rstn;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fires;
        n_tests = 0;
        n_fail  = 0;
        rst_ni  = 1'b0;
        u_if.req_valid_i  = '0;
        u_if.req_opcode_i = '0;
        u_if.req_size_i   = '0;
        u_if.dev_ready_i  = 1'b0;

        // reset, idle
        vecs.push_back(mk(2'b00, GET,3, GET,3, 1,0, 0,2'b00,0,0));
        vecs.push_back(mk(2'b00, GET,3, GET,3, 1,1, 0,2'b00,0,0));
        // single-beat Gets from both hosts alternate
        vecs.push_back(mk(2'b11, GET,3, GET,3, 1,1, 1,2'b01,0,0));
        vecs.push_back(mk(2'b11, GET,3, GET,3, 1,1, 1,2'b10,1,0));
        vecs.push_back(mk(2'b11, GET,3, GET,3, 1,1, 1,2'b01,0,0));
        vecs.push_back(mk(2'b11, GET,3, GET,3, 1,1, 1,2'b10,1,0));
        // 4-beat PutFull from host 0 while host 1 waits
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b01,0,0));
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b01,0,1));
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b01,0,1));
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b01,0,1));
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b10,1,0));
        vecs.push_back(mk(2'b00, GET,3, GET,3, 1,1, 0,2'b00,0,0));
        // host 1 stalled by the device, host 0 arrives during the stall
        vecs.push_back(mk(2'b10, GET,3, GET,3, 0,1, 1,2'b00,1,0));
        vecs.push_back(mk(2'b11, GET,3, GET,3, 0,1, 1,2'b00,1,1));
        vecs.push_back(mk(2'b11, GET,3, GET,3, 0,1, 1,2'b00,1,1));
        vecs.push_back(mk(2'b11, GET,3, GET,3, 1,1, 1,2'b10,1,1));
        vecs.push_back(mk(2'b01, GET,3, GET,3, 1,1, 1,2'b01,0,0));
        vecs.push_back(mk(2'b00, GET,3, GET,3, 1,1, 0,2'b00,0,0));
        // burst with the locked host dropping valid for two cycles
        vecs.push_back(mk(2'b01, PF,5,  GET,3, 1,1, 1,2'b01,0,0));
        vecs.push_back(mk(2'b01, PF,5,  GET,3, 1,1, 1,2'b01,0,1));
        vecs.push_back(mk(2'b10, PF,5,  GET,3, 1,1, 0,2'b01,0,1));
        vecs.push_back(mk(2'b10, PF,5,  GET,3, 1,1, 0,2'b01,0,1));
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b01,0,1));
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b01,0,1));
        vecs.push_back(mk(2'b11, PF,5,  GET,3, 1,1, 1,2'b10,1,0));
        vecs.push_back(mk(2'b00, GET,3, GET,3, 1,1, 0,2'b00,0,0));

        foreach (vecs[i]) begin
            @(negedge clk_i);
            apply(vecs[i]);
            #2;
            chk($sformatf("v%0d dev_valid", i), 32'(u_if.dev_valid_o), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d req_ready", i), 32'(u_if.req_ready_o), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d sel", i),       32'(u_if.sel_o),       32'(vecs[i].e_sel));
            chk($sformatf("v%0d busy", i),      32'(u_if.busy_o),      32'(vecs[i].e_busy));
        end

        // reset asserted after two beats of a four-beat burst
        @(negedge clk_i);
        apply(mk(2'b11, PF,5, GET,3, 1,1, 0,2'b00,0,0));
        fires = 0;
        for (int c = 0; c < 8 && fires < 2; c++) begin
            if (c != 0) @(negedge clk_i);
            #2;
            if (u_if.dev_valid_o && u_if.req_ready_o[0]) fires++;
        end
        chk("beats before reset", 32'(fires), 32'd2);
        @(negedge clk_i);
        #2;
        chk("busy mid-burst", 32'(u_if.busy_o), 32'd1);
        chk("sel mid-burst", 32'(u_if.sel_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("busy in reset", 32'(u_if.busy_o), 32'd0);
        chk("sel in reset", 32'(u_if.sel_o), 32'd0);
        chk("ready in reset", 32'(u_if.req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        u_if.req_opcode_i = {GET, GET};
        u_if.req_size_i   = {3'd3, 3'd3};
        #2;
        chk("tie after reset sel", 32'(u_if.sel_o), 32'd0);
        chk("tie after reset ready", 32'(u_if.req_ready_o), 32'd1);
        chk("tie after reset busy", 32'(u_if.busy_o), 32'd0);
        @(negedge clk_i);
        #2;
        chk("next grant sel", 32'(u_if.sel_o), 32'd1);
        chk("next grant ready", 32'(u_if.req_ready_o), 32'd2);
        @(negedge clk_i);
        u_if.req_valid_i = '0;
        #2;
        chk("final idle valid", 32'(u_if.dev_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
